// File: rtl/ws2812b_pkg.sv
// Shared types and default 64 MHz timing for the WS2812B serial line driver.
package ws2812b_pkg;

  localparam int unsigned PIXEL_W = 24;

  localparam int unsigned DEF_BIT_CYCLES   = 80;
  localparam int unsigned DEF_T0H_CYCLES   = 26;
  localparam int unsigned DEF_T1H_CYCLES   = 51;
  localparam int unsigned DEF_LATCH_CYCLES = 5120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_e;

endpackage

// File: rtl/ws2812b_serializer.sv
// Serializes one 24-bit GRB pixel per handshake into the WS2812B NRZ waveform,
// optionally followed by the low reset/latch period.
//
// state | meaning
// IDLE  | ready=1, led=0, waiting for valid
// HIGH  | high part of the current bit (T1H or T0H)
// LOW   | low remainder of the bit period
// LATCH | led held low for the latch period, ready=0
module ws2812b_serializer
  import ws2812b_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIXEL_W-1:0] data_in,
  input  logic               valid,
  input  logic               latch,
  output logic               ready,
  output logic               led
);

  localparam int unsigned CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Terminal counts: each phase lasts (TC + 1) cycles from its entry at count 0.
  localparam cnt_t T0H_TC   = cnt_t'(T0H_CYCLES - 1);
  localparam cnt_t T1H_TC   = cnt_t'(T1H_CYCLES - 1);
  localparam cnt_t T0L_TC   = cnt_t'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam cnt_t T1L_TC   = cnt_t'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam cnt_t LATCH_TC = cnt_t'(LATCH_CYCLES - 1);

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
        T1H_CYCLES < BIT_CYCLES && LATCH_CYCLES >= 1)) begin : g_bad_timing
    $error("ws2812b_serializer: need 0 < T0H < T1H < BIT and LATCH >= 1");
  end

  state_e             state_q, state_d;
  cnt_t               cyc_cnt_q, cyc_cnt_d;
  logic [PIXEL_W-1:0] shift_q, shift_d;
  logic [4:0]         bit_idx_q, bit_idx_d;
  logic               latch_q, latch_d;
  logic               led_q, led_d;
  logic               ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q + 1'b1;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    latch_d   = latch_q;
    led_d     = led_q;
    ready_d   = ready_q;

    case (state_q)
      IDLE: begin
        cyc_cnt_d = '0;
        if (valid && ready_q) begin
          shift_d   = data_in;
          latch_d   = latch;
          bit_idx_d = 5'(PIXEL_W - 1);
          state_d   = HIGH;
          led_d     = 1'b1;
          ready_d   = 1'b0;
        end
      end
      HIGH: begin
        if (cyc_cnt_q == (shift_q[PIXEL_W-1] ? T1H_TC : T0H_TC)) begin
          state_d   = LOW;
          led_d     = 1'b0;
          cyc_cnt_d = '0;
        end
      end
      LOW: begin
        // shift_q still holds the bit just sent, so the low time completes its period.
        if (cyc_cnt_q == (shift_q[PIXEL_W-1] ? T1L_TC : T0L_TC)) begin
          cyc_cnt_d = '0;
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[PIXEL_W-2:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
            state_d   = HIGH;
            led_d     = 1'b1;
          end else if (latch_q) begin
            state_d = LATCH;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      LATCH: begin
        if (cyc_cnt_q == LATCH_TC) begin
          state_d   = IDLE;
          ready_d   = 1'b1;
          cyc_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        cyc_cnt_d = '0;
        led_d     = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      latch_q   <= 1'b0;
      led_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      latch_q   <= latch_d;
      led_q     <= led_d;
      ready_q   <= ready_d;
    end
  end

  assign led   = led_q;
  assign ready = ready_q;

endmodule
